// File: rtl/bfm_ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the byte-lane helper
// used by the bench slave memory model.
package bfm_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Little-endian lane enables; unsupported sizes enable nothing.
    function automatic logic [3:0] lane_en(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            HSIZE_BYTE: lane_en = 4'b0001 << addr;
            HSIZE_HALF: lane_en = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: lane_en = 4'b1111;
            default:    lane_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/bfm_ahb_mem_core.sv
// Word-wide RAM with per-byte write enables and an asynchronous read port.
module bfm_ahb_mem_core #(
    parameter int DEPTH = 256,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input  logic            i_clk,
    input  logic [3:0]      i_be,
    input  logic [IDXW-1:0] i_waddr,
    input  logic [31:0]     i_wdata,
    input  logic [IDXW-1:0] i_raddr,
    output logic [31:0]     o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_be[i]) begin
                r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bfm_ahbslave_mem.sv
// AHB-Lite slave memory with programmable wait states, byte/half lane writes,
// ERROR responses for bad transfers and a completed-transfer counter.
module bfm_ahbslave_mem
    import bfm_ahb_pkg::*;
#(
    parameter int AWIDTH    = 12,
    parameter int DEPTH     = 256,
    parameter int MAX_WS    = 15,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETN,
    input  logic                 HSEL,
    input  logic [AWIDTH-1:0]    HADDR,
    input  logic                 HWRITE,
    input  logic [1:0]           HTRANS,
    input  logic [2:0]           HSIZE,
    input  logic [2:0]           HBURST,
    input  logic                 HMASTLOCK,
    input  logic [3:0]           HPROT,
    input  logic [31:0]          HWDATA,
    input  logic                 HREADYIN,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    input  logic [3:0]           WAIT_CFG,
    output logic [CNT_WIDTH-1:0] XFER_CNT
);

    localparam int                   IDXW       = $clog2(DEPTH);
    localparam int                   LAW        = IDXW + 2;
    localparam logic [AWIDTH:0]      ADDR_LIMIT = (AWIDTH+1)'(DEPTH * 4);
    localparam logic [3:0]           WS_MAX     = 4'(MAX_WS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic                   r_pend;
    logic [31:0]            r_hrdata;
    logic [CNT_WIDTH-1:0]   r_xfer_cnt;
    logic [LAW-1:0]         r_addr;
    logic                   r_write;
    logic [2:0]             r_size;

    state_t                 w_state_nxt;
    logic [3:0]             w_cnt_nxt;
    logic                   w_pend_nxt;
    logic                   w_rd_load;
    logic                   w_hready;
    logic                   w_hresp;
    logic                   w_addr_slot;
    logic                   w_accept;
    logic                   w_err;
    logic [3:0]             w_ws;
    logic [3:0]             w_commit_be;
    logic [IDXW-1:0]        w_rd_idx;
    logic [31:0]            w_mem_rdata;
    logic [31:0]            w_rd_word;
    logic                   w_unused;

    assign w_unused = ^{HBURST, HMASTLOCK, HPROT, HTRANS[0]};

    // Address phases are only taken when no wait or first error cycle is pending.
    assign w_addr_slot = (r_state == ST_IDLE) || (r_state == ST_ERR2);
    assign w_accept    = HSEL & HREADYIN & HTRANS[1] & w_addr_slot;

    assign w_err = ({1'b0, HADDR} >= ADDR_LIMIT)
                 | (HSIZE > HSIZE_WORD)
                 | ((HSIZE == HSIZE_HALF) & HADDR[0])
                 | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));

    assign w_ws = (WAIT_CFG > WS_MAX) ? WS_MAX : WAIT_CFG;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = 1'b0;
        w_rd_load   = 1'b0;
        w_hready    = 1'b1;
        w_hresp     = HRESP_OKAY;
        case (r_state)
            ST_WAIT: begin
                w_hready = 1'b0;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                    w_pend_nxt  = 1'b1;
                    w_rd_load   = !r_write;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_ERR1: begin
                w_hready    = 1'b0;
                w_hresp     = HRESP_ERROR;
                w_state_nxt = ST_ERR2;
            end
            default: begin
                w_hresp     = (r_state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
                w_state_nxt = ST_IDLE;
                if (w_accept) begin
                    if (w_err) begin
                        w_state_nxt = ST_ERR1;
                    end else if (w_ws != 4'd0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = w_ws - 4'd1;
                    end else begin
                        w_pend_nxt = 1'b1;
                        w_rd_load  = !HWRITE;
                    end
                end
            end
        endcase
    end

    // r_pend marks the final data cycle of a good transfer; writes commit as it ends.
    assign w_commit_be = (r_pend && r_write) ? lane_en(r_size, r_addr[1:0]) : 4'b0000;
    assign w_rd_idx    = (r_state == ST_WAIT) ? r_addr[LAW-1:2] : HADDR[LAW-1:2];

    always_comb begin
        w_rd_word = w_mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (w_commit_be[i] && (w_rd_idx == r_addr[LAW-1:2])) begin
                w_rd_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    bfm_ahb_mem_core #(
        .DEPTH (DEPTH),
        .IDXW  (IDXW)
    ) u_mem (
        .i_clk   (HCLK),
        .i_be    (w_commit_be),
        .i_waddr (r_addr[LAW-1:2]),
        .i_wdata (HWDATA),
        .i_raddr (w_rd_idx),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_pend     <= 1'b0;
            r_hrdata   <= 32'd0;
            r_xfer_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pend   <= w_pend_nxt;
            r_hrdata <= w_rd_load ? w_rd_word : 32'd0;
            if (r_pend) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_accept) begin
            r_addr  <= HADDR[LAW-1:0];
            r_write <= HWRITE;
            r_size  <= HSIZE;
        end
    end

    assign HREADYOUT = w_hready;
    assign HRESP     = w_hresp;
    assign HRDATA    = r_hrdata;
    assign XFER_CNT  = r_xfer_cnt;

endmodule

// File: tb/tb_bfm_ahbslave_mem.sv
// Bench for bfm_ahbslave_mem: a cycle-level AHB master driving queued transfers,
// checked against a byte-array memory model with simple response rules.
module tb_bfm_ahbslave_mem;

    localparam int AW    = 12;
    localparam int DEPTH = 256;
    localparam int MAXWS = 10;
    localparam int CW    = 5;

    logic          HCLK = 1'b0;
    logic          HRESETN = 1'b0;
    logic          HSEL = 1'b0;
    logic [AW-1:0] HADDR = '0;
    logic          HWRITE = 1'b0;
    logic [1:0]    HTRANS = 2'd0;
    logic [2:0]    HSIZE = 3'd0;
    logic [2:0]    HBURST = 3'd0;
    logic          HMASTLOCK = 1'b0;
    logic [3:0]    HPROT = 4'd0;
    logic [31:0]   HWDATA = 32'd0;
    logic          HREADYIN;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [3:0]    WAIT_CFG = 4'd0;
    logic [CW-1:0] XFER_CNT;

    assign HREADYIN = HREADYOUT;

    always #5 HCLK = ~HCLK;

    bfm_ahbslave_mem #(
        .AWIDTH    (AW),
        .DEPTH     (DEPTH),
        .MAX_WS    (MAXWS),
        .CNT_WIDTH (CW)
    ) dut (
        .HCLK      (HCLK),
        .HRESETN   (HRESETN),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HMASTLOCK (HMASTLOCK),
        .HPROT     (HPROT),
        .HWDATA    (HWDATA),
        .HREADYIN  (HREADYIN),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .WAIT_CFG  (WAIT_CFG),
        .XFER_CNT  (XFER_CNT)
    );

    typedef struct {
        bit          wr;
        int          addr;
        int          size;
        logic [31:0] wdata;
        int          cfg;
        int          gap;
        bit          kill;
    } xfer_t;

    xfer_t       q[$];
    xfer_t       dp;
    logic [7:0]  mbyte [0:DEPTH*4-1];
    int          n_checks = 0;
    int          n_fail = 0;
    int          model_cnt = 0;
    bit          have_dp = 0;
    bit          dp_err = 0;
    int          dp_ws = 0;
    int          n_low = 0;
    int          dp_bad = 0;
    int          idle_bad = 0;
    bit          abort = 0;
    logic [31:0] last_rdata = 32'd0;
    int          last_low = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mword(input int idx);
        return {mbyte[4*idx+3], mbyte[4*idx+2], mbyte[4*idx+1], mbyte[4*idx]};
    endfunction

    function automatic bit is_err(input int addr, input int size);
        if (size > 2) return 1'b1;
        if (addr >= DEPTH * 4) return 1'b1;
        return (addr % (1 << size)) != 0;
    endfunction

    task automatic enq(input bit wr, input int addr, input int size, input logic [31:0] wdata,
                       input int cfg, input int gap, input bit kill);
        xfer_t t;
        t.wr = wr; t.addr = addr; t.size = size; t.wdata = wdata;
        t.cfg = cfg; t.gap = gap; t.kill = kill;
        q.push_back(t);
    endtask

    task automatic run_queue();
        bit          slot;
        bit          issue;
        bit          done;
        logic [31:0] exp;
        while (!abort && (q.size() > 0 || have_dp)) begin
            slot  = !have_dp || (HREADYOUT === 1'b1);
            issue = 1'b0;
            done  = 1'b0;
            if (slot && q.size() > 0) begin
                if (q[0].gap > 0) q[0].gap = q[0].gap - 1;
                else issue = 1'b1;
            end
            if (have_dp) begin
                if (HREADYOUT !== 1'b1) begin
                    n_low++;
                    if (HRESP !== dp_err || HRDATA !== 32'd0) dp_bad++;
                    if (n_low > 40) begin
                        chk("timeout", n_low, dp_ws);
                        abort = 1'b1;
                    end else if (dp.kill && n_low == 2) begin
                        HRESETN = 1'b0;
                        HSEL = 1'b0;
                        HTRANS = 2'd0;
                        #1;
                        chk("rst_hready", 32'(HREADYOUT), 32'd1);
                        chk("rst_hresp", 32'(HRESP), 32'd0);
                        chk("rst_hrdata", HRDATA, 32'd0);
                        chk("rst_cnt", 32'(XFER_CNT), 32'd0);
                        model_cnt = 0;
                        have_dp = 1'b0;
                        @(negedge HCLK);
                        HRESETN = 1'b1;
                        @(posedge HCLK);
                        #1;
                        continue;
                    end
                end else begin
                    chk("wait_states", n_low, dp_ws);
                    chk("dp_phase", dp_bad, 0);
                    chk("hresp", 32'(HRESP), 32'(dp_err));
                    exp = (dp.wr || dp_err) ? 32'd0 : mword(dp.addr / 4);
                    chk("hrdata", HRDATA, exp);
                    if (!dp.wr && !dp_err) last_rdata = HRDATA;
                    last_low = n_low;
                    done = 1'b1;
                end
            end else if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'd0) begin
                idle_bad++;
            end
            if (abort) break;

            HWDATA = (have_dp && dp.wr) ? dp.wdata : $urandom;
            if (issue) begin
                HSEL     = 1'b1;
                HTRANS   = 2'($urandom_range(2, 3));
                HADDR    = AW'(q[0].addr);
                HWRITE   = q[0].wr;
                HSIZE    = 3'(q[0].size);
                WAIT_CFG = 4'(q[0].cfg);
            end else begin
                case ($urandom_range(0, 2))
                    0:       begin HSEL = 1'b0; HTRANS = 2'($urandom_range(2, 3)); end
                    1:       begin HSEL = 1'b1; HTRANS = 2'd0; end
                    default: begin HSEL = 1'b1; HTRANS = 2'd1; end
                endcase
                HADDR    = AW'($urandom);
                HWRITE   = 1'($urandom_range(0, 1));
                HSIZE    = 3'($urandom_range(0, 2));
                WAIT_CFG = 4'($urandom_range(0, 15));
            end

            @(posedge HCLK);
            #1;
            if (done) begin
                if (!dp_err) begin
                    if (dp.wr) begin
                        for (int b = 0; b < (1 << dp.size); b++) begin
                            int a;
                            a = dp.addr + b;
                            mbyte[a] = dp.wdata[8*(a % 4) +: 8];
                        end
                    end
                    model_cnt = (model_cnt + 1) % (1 << CW);
                end
                have_dp = 1'b0;
                chk("xfer_cnt", 32'(XFER_CNT), model_cnt);
            end
            if (issue) begin
                dp      = q.pop_front();
                dp_err  = is_err(dp.addr, dp.size);
                dp_ws   = dp_err ? 1 : ((dp.cfg > MAXWS) ? MAXWS : dp.cfg);
                have_dp = 1'b1;
                n_low   = 0;
                dp_bad  = 0;
            end
        end
        chk("idle_ok", idle_bad, 0);
        idle_bad = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=%0t exp=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_word;
        int          saved_cnt;
        int          addr;
        int          size;

        repeat (2) @(posedge HCLK);
        #1;
        chk("reset_hready", 32'(HREADYOUT), 32'd1);
        chk("reset_hresp", 32'(HRESP), 32'd0);
        chk("reset_hrdata", HRDATA, 32'd0);
        chk("reset_cnt", 32'(XFER_CNT), 32'd0);
        @(negedge HCLK);
        HRESETN = 1'b1;
        @(posedge HCLK);
        #1;

        enq(1, 'h010, 2, 32'hDEADBEEF, 0, 1, 0);
        enq(0, 'h010, 2, 32'd0, 0, 1, 0);
        run_queue();
        chk("plan_word_rd", last_rdata, 32'hDEADBEEF);
        chk("plan_cnt2", 32'(XFER_CNT), 32'd2);
        chk("plan_no_wait", last_low, 0);

        for (int i = 0; i < DEPTH; i++) begin
            enq(1, i * 4, 2, (i == 4) ? 32'hDEADBEEF : 32'($urandom), 0, 0, 0);
        end
        run_queue();

        enq(0, 'h010, 2, 32'd0, 3, 1, 0);
        run_queue();
        chk("plan_ws3", last_low, 3);
        chk("plan_ws3_rd", last_rdata, 32'hDEADBEEF);

        enq(1, 'h012, 0, 32'h0055_0000, 0, 1, 0);
        enq(1, 'h010, 1, 32'h0000_A1B2, 1, 0, 0);
        enq(0, 'h010, 2, 32'd0, 0, 1, 0);
        run_queue();
        chk("plan_lanes", last_rdata, 32'hDE55A1B2);

        saved_cnt = model_cnt;
        enq(0, 'h400, 2, 32'd0, 2, 1, 0);
        enq(1, 'h011, 1, 32'hFFFF_FFFF, 4, 1, 0);
        run_queue();
        chk("plan_err_cnt", 32'(XFER_CNT), saved_cnt);
        enq(0, 'h010, 2, 32'd0, 0, 1, 0);
        run_queue();
        chk("plan_err_nowr", last_rdata, 32'hDE55A1B2);

        enq(1, 'h020, 2, 32'h12345678, 0, 0, 0);
        enq(0, 'h020, 2, 32'd0, 0, 0, 0);
        run_queue();
        chk("plan_fwd", last_rdata, 32'h12345678);

        old_word = mword('h030 / 4);
        enq(1, 'h030, 2, ~old_word, 5, 1, 1);
        enq(0, 'h030, 2, 32'd0, 0, 2, 0);
        run_queue();
        chk("plan_rst_old", last_rdata, old_word);

        for (int i = 0; i < 300; i++) begin
            size = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
            addr = $urandom_range(0, 1279);
            if ($urandom_range(0, 3) != 0 && size <= 2) addr = addr & ~((1 << size) - 1);
            enq(1'($urandom_range(0, 1)), addr, size, 32'($urandom),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2),
                $urandom_range(0, 2), 0);
        end
        run_queue();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
